// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle radix-2 multiply/divide unit producing the HI/LO register pair
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(ITER + 1);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t state, state_nx;
   logic [2:0] op_q;
   logic [WIDTH-1:0] x, y, a_q, mag_a, mag_b, q, r, qf, rf;
   logic sa, sb, a_neg, b_neg, sgn_op, issue, mt, arith, is_div;
   logic [2*WIDTH-1:0] work, step_nx, hl, sprod, div_res, res;
   logic [WIDTH:0] mul_sum, rem_sh, diff;
   logic [CW-1:0] cnt;
   // Issue decode, operand magnitudes, one iteration step and the final sign-corrected result
   always_comb begin
      sgn_op = op[2] ? !op[1] : !op[0];
      issue = state == IDLE && start && !flush;
      mt = issue && op[2:1] == 2'b11;
      arith = issue && !mt;
      a_neg = sgn_op && a[WIDTH-1];
      b_neg = sgn_op && b[WIDTH-1];
      mag_a = a_neg ? -a : a;
      mag_b = b_neg ? -b : b;
      is_div = op_q[2:1] == 2'b01;
      mul_sum = {1'b0, work[2*WIDTH-1:WIDTH]} + (y[0] ? {1'b0, x} : '0);
      rem_sh = {work[2*WIDTH-1:WIDTH], y[WIDTH-1]};
      diff = rem_sh - {1'b0, x};
      step_nx = !is_div ? {mul_sum, work[WIDTH-1:1]} :
                diff[WIDTH] ? {rem_sh[WIDTH-1:0], work[WIDTH-2:0], 1'b0} :
                {diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
      hl = {hi, lo};
      sprod = (sa ^ sb) ? -work : work;
      q = work[WIDTH-1:0];
      r = work[2*WIDTH-1:WIDTH];
      qf = (sa ^ sb) ? -q : q;
      rf = sa ? -r : r;
      div_res = (x == '0) ? {a_q, {WIDTH{1'b1}}} : {rf, qf};
      res = is_div ? div_res : op_q[2] ? (op_q[0] ? hl - sprod : hl + sprod) : sprod;
   end
   // State register
   always_ff @(posedge Clk)
      state <= !Rst ? IDLE : state_nx;
   // Next-state: flush aborts any in-flight operation, RUN lasts ITER edges, FIX lasts one
   always_comb
      state_nx = (flush && state != IDLE) ? IDLE :
                 state == IDLE ? (arith ? RUN : IDLE) :
                 state == RUN ? (cnt == CW'(ITER - 1) ? FIX : RUN) : IDLE;
   // Outputs decoded from state
   always_comb
      busy = state != IDLE;
   // Datapath: operand latch, iteration, HI/LO writes and the done pulse
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         hi <= '0;
         lo <= '0;
         done <= 1'b0;
         cnt <= '0;
         work <= '0;
      end else begin
         done <= 1'b0;
         if (mt) begin
            if (op[0]) lo <= a;
            else hi <= a;
            done <= 1'b1;
         end
         if (arith) begin
            op_q <= op;
            x <= op[1] ? mag_b : mag_a;
            y <= op[1] ? mag_a : mag_b;
            sa <= a_neg;
            sb <= b_neg;
            a_q <= a;
            work <= '0;
            cnt <= '0;
         end
         if (state == RUN && !flush) begin
            work <= step_nx;
            y <= is_div ? y << 1 : y >> 1;
            cnt <= cnt + 1'b1;
         end
         if (state == FIX && !flush) begin
            {hi, lo} <= res;
            done <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
   logic Clk = 0, Rst = 0, start = 0, flush = 0;
   logic [2:0] op = 0;
   logic [31:0] a = 0, b = 0, hi, lo;
   logic busy, done;
   int n_chk = 0, n_fail = 0;
   logic [31:0] hi_m = 0, lo_m = 0;

   muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
      .Clk(Clk), .Rst(Rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
      .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [63:0] hl);
      longint sx, sy, p, sq, sr;
      logic [31:0] uq, ur, q32, r32;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      p = sx * sy;
      case (o)
         3'd0: return p;
         3'd1: return {32'b0, x} * {32'b0, y};
         3'd2: begin
            if (y == 0) return {x, 32'hFFFFFFFF};
            sq = sx / sy;
            sr = sx % sy;
            q32 = sq[31:0];
            r32 = sr[31:0];
            return {r32, q32};
         end
         3'd3: begin
            if (y == 0) return {x, 32'hFFFFFFFF};
            uq = x / y;
            ur = x % y;
            return {ur, uq};
         end
         3'd4: return hl + p;
         3'd5: return hl - p;
         3'd6: return {x, hl[31:0]};
         default: return {hl[63:32], x};
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   // Issue one op at a negedge, follow it to completion and compare with the model
   task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit gap);
      logic [63:0] exp;
      int n;
      bit dseen;
      exp = model(o, x, y, {hi_m, lo_m});
      start = 1; op = o; a = x; b = y;
      @(negedge Clk);
      start = 0;
      if (o[2:1] == 2'b11) begin
         check("mt_busy", busy, 0);
         check("mt_done", done, 1);
      end else begin
         n = 0;
         dseen = 0;
         while (busy && n < 100) begin
            if (done) dseen = 1;
            if (n == 16) check("hold", {hi, lo}, {hi_m, lo_m});
            n++;
            @(negedge Clk);
         end
         check("busy_len", n, 33);
         check("done_early", dseen, 0);
         check("done", done, 1);
      end
      check("hilo", {hi, lo}, exp);
      {hi_m, lo_m} = exp;
      if (gap) begin
         @(negedge Clk);
         check("done_pulse", done, 0);
      end
   endtask

   initial begin
      repeat (2) @(negedge Clk);
      check("rst_hilo", {hi, lo}, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      Rst = 1;
      @(negedge Clk);
      do_op(3'd0, 32'hFFFFFFFF, 32'd7, 1);
      check("tp_mult", {hi, lo}, 64'hFFFFFFFF_FFFFFFF9);
      do_op(3'd1, 32'hFFFFFFFF, 32'd7, 1);
      check("tp_multu", {hi, lo}, 64'h00000006_FFFFFFF9);
      do_op(3'd2, 32'hFFFFFFF9, 32'd2, 0);
      check("tp_div", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      do_op(3'd3, 32'd100, 32'd0, 1);
      check("tp_div0", {hi, lo}, 64'h00000064_FFFFFFFF);
      do_op(3'd6, 32'h0, 32'h0, 1);
      do_op(3'd7, 32'hFFFFFFFF, 32'h0, 1);
      do_op(3'd4, 32'd1, 32'd1, 1);
      check("tp_madd", {hi, lo}, 64'h00000001_00000000);
      do_op(3'd5, 32'd1, 32'd1, 1);
      check("tp_msub", {hi, lo}, 64'h00000000_FFFFFFFF);
      do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1);
      check("tp_divovf", {hi, lo}, 64'h00000000_80000000);
      // flush during RUN with a stray start that must be ignored
      start = 1; op = 3'd0; a = 3; b = 5;
      @(negedge Clk);
      start = 0;
      repeat (5) @(negedge Clk);
      start = 1; op = 3'd6; a = 32'hDEAD;
      @(negedge Clk);
      start = 0;
      repeat (4) @(negedge Clk);
      flush = 1;
      @(negedge Clk);
      flush = 0;
      check("flush_busy", busy, 0);
      for (int i = 0; i < 4; i++) begin
         check("flush_done", done, 0);
         check("flush_hilo", {hi, lo}, {hi_m, lo_m});
         @(negedge Clk);
      end
      // flush in IDLE suppresses a start
      start = 1; op = 3'd6; a = 32'h1234; flush = 1;
      @(negedge Clk);
      start = 0; flush = 0;
      check("iflush_done", done, 0);
      check("iflush_busy", busy, 0);
      check("iflush_hi", hi, hi_m);
      // reset in the middle of a divide
      start = 1; op = 3'd2; a = 100; b = 7;
      @(negedge Clk);
      start = 0;
      repeat (20) @(negedge Clk);
      Rst = 0;
      @(negedge Clk);
      Rst = 1;
      check("mrst_hilo", {hi, lo}, 0);
      check("mrst_busy", busy, 0);
      check("mrst_done", done, 0);
      hi_m = 0; lo_m = 0;
      do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1);
      check("tp_divu", {hi, lo}, 64'h80000000_00000000);
      for (int i = 0; i < 40; i++) do_op(3'($urandom_range(0, 7)), pick(), pick(), i[0]);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit that sits downstream of the EX stage's ALU operand muxes.
- Accepts rs/rt operands and a HI/LO operation at issue, iterates radix-2 over 32 cycles, and produces the architectural HI/LO register pair that WB reads for MFHI/MFLO.
- Exports busy so the hazard logic can stall issue of dependent and further HI/LO instructions.

Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH bits.
- ITER, 32, number of iteration cycles in RUN; must equal WIDTH.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  synchronous reset, active-low (Rst=0 sampled at a rising Clk edge resets).
- start  in  1  issue strobe, sampled only in IDLE.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB, 110 MTHI, 111 MTLO.
- a  in  WIDTH  rs operand (dividend / multiplicand / MT source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- flush  in  1  abort in-flight operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  high while in RUN or FIX.
- done  out  1  one-cycle pulse after HI/LO update.

Behaviour:
- Reset (Rst=0 at an edge): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset overrides all other inputs, including an in-flight operation; partial results are discarded.
- FSM states: IDLE, RUN, FIX.
- IDLE & start & op=110/111, edge E0: hi (MTHI) or lo (MTLO) is written with a. done=1 in the next cycle. The state stays IDLE and busy stays 0.
- IDLE & start & op in 000-101, edge E0:
  - Latch op, the operand magnitudes, and the operand sign flags. Signs are used only for 000, 010, 100, 101.
  - Clear the 64-bit working register and counter. Go to RUN.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. The counter increments each edge. After edge E32 (counter reaches ITER), go to FIX.
- FIX, edge E33:
  - Apply sign correction.
  - MADD/MSUB: {hi,lo} = {hi,lo} +/- signed 64-bit product, wrapping mod 2^64.
  - Write hi/lo. done=1 in the cycle after E33. Return to IDLE.
- Latency and handshake:
  - busy=1 in the cycles after E0 through E32.
  - New hi/lo are visible in the cycle after E33, so a back-to-back start can be accepted at E34.
- start while busy=1: ignored, with no queueing. Upstream must stall on busy.
- MULT/MULTU: {hi,lo} = full 64-bit product, signed or unsigned respectively.
- DIV/DIVU: lo=quotient, hi=remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (b=0, DIV or DIVU): lo=0xFFFFFFFF, hi=a unchanged. No exception. Latency is the same as any other divide.
- flush=1:
  - In RUN or FIX: return to IDLE at that edge. hi/lo are unchanged, done stays 0, and busy=0 in the next cycle.
  - In IDLE: suppresses start at that edge.
  - Simultaneous flush and start: flush wins.
- done: high only in the single cycle following a hi/lo write. It is 0 otherwise, including after a flush.
- hi/lo change only at E0 (MT ops) or at E33. They hold their value at all other times.

Test Plan:
- Reset, then MULT with a=0xFFFFFFFF, b=7 -> after 34 edges hi=0xFFFFFFFF, lo=0xFFFFFFF9. busy is high for 33 cycles and done pulses once.
- MULTU with a=0xFFFFFFFF, b=7 -> hi=0x00000006, lo=0xFFFFFFF9.
- DIV with a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU with a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
- MTHI a=0, MTLO a=0xFFFFFFFF, then MADD a=1, b=1 -> hi=1, lo=0. Then MSUB a=1, b=1 -> hi=0, lo=0xFFFFFFFF. Each MT op gives done the next cycle with no busy.
- Start MULT a=3, b=5, assert flush at RUN counter=10, and also pulse start during RUN -> busy=0 the next cycle, hi/lo keep their prior values, done never pulses, and the extra start is ignored.
- Start DIV, drive Rst=0 at counter=20 -> hi=lo=0, busy=0, done=0 after that edge. Then DIVU a=0x80000000, b=0xFFFFFFFF -> lo=0, hi=0x80000000.
